// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator scheduler slice.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door timing; holds at zero.
// Latency: load/decrement take effect at the next rising edge; zero is combinational from the count.
module elevator_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && !zero) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-policy elevator controller: latches call buttons, sweeps one direction, opens the door at called floors.
// Latency: requests are seen at the edge they are sampled; no backpressure, requests are latched until served.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_req,
    output logic [NUM_FLOORS-1:0] floor_pos,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open
);

    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]         TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0]         DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] BOTTOM      = NUM_FLOORS'(1);

    state_t                  state, state_nxt;
    logic [NUM_FLOORS-1:0]   pos_nxt, pend_nxt, req_all;
    logic [NUM_FLOORS-1:0]   above, below, next_pos, ahead_next;
    logic                    dir_nxt, seen_up, seen_dn;
    logic                    tmr_load, tmr_dec, tmr_zero;
    logic [CW-1:0]           tmr_val;

    elevator_timer #(
        .WIDTH(CW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (tmr_load),
        .value(tmr_val),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    assign req_all = pending | floor_req;

    // Floors strictly above / below the car, built from the one-hot position alone.
    always_comb begin
        above   = '0;
        below   = '0;
        seen_up = 1'b0;
        seen_dn = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above[i] = seen_up;
            seen_up  = seen_up | floor_pos[i];
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            below[i] = seen_dn;
            seen_dn  = seen_dn | floor_pos[i];
        end
    end

    // Saturating one-floor step; the masks of the next floor are the current masks minus that floor.
    assign next_pos   = dir_up ? (floor_pos[NUM_FLOORS-1] ? floor_pos : floor_pos << 1)
                               : (floor_pos[0] ? floor_pos : floor_pos >> 1);
    assign ahead_next = (dir_up ? above : below) & ~next_pos;

    always_comb begin
        state_nxt = state;
        pos_nxt   = floor_pos;
        pend_nxt  = req_all;
        dir_nxt   = dir_up;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = TRAVEL_LOAD;
        case (state)
            IDLE: begin
                if (|(req_all & floor_pos)) begin
                    state_nxt = DOOR;
                    pend_nxt  = req_all & ~floor_pos;
                    tmr_load  = 1'b1;
                    tmr_val   = DOOR_LOAD;
                end else if (|req_all) begin
                    state_nxt = MOVE;
                    dir_nxt   = (|(req_all & above)) && (dir_up || !(|(req_all & below)));
                    tmr_load  = 1'b1;
                end
            end
            MOVE: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    pos_nxt = next_pos;
                    if (|(req_all & next_pos)) begin
                        state_nxt = DOOR;
                        pend_nxt  = req_all & ~next_pos;
                        tmr_load  = 1'b1;
                        tmr_val   = DOOR_LOAD;
                    end else if (|(req_all & ahead_next)) begin
                        tmr_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR: begin
                // A call for this floor while the door is open just keeps it open longer.
                pend_nxt = req_all & ~floor_pos;
                if (|(floor_req & floor_pos)) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (tmr_zero) begin
                    state_nxt = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            floor_pos <= BOTTOM;
            pending   <= '0;
            dir_up    <= 1'b1;
        end else begin
            state     <= state_nxt;
            floor_pos <= pos_nxt;
            pending   <= pend_nxt;
            dir_up    <= dir_nxt;
        end
    end

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: floor-number model compared every cycle plus hand-computed scenario checks.
module tb_elevator_scheduler;

    localparam int N      = 5;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] floor_req;
    logic [N-1:0] floor_pos, pending;
    logic         moving, dir_up, door_open;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    elevator_scheduler #(
        .NUM_FLOORS   (N),
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .floor_req(floor_req),
        .floor_pos(floor_pos),
        .pending  (pending),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_open(door_open)
    );

    always #5 clk = ~clk;

    // Model: floor as an integer 0..N-1, a cycles-left count per activity.
    int       m_floor = 0;
    bit [N-1:0] m_pend = '0;
    bit       m_mov = 0, m_door = 0, m_dir = 1;
    int       m_left = 0;

    function automatic bit any_ahead(input bit [N-1:0] p, input int f, input bit up);
        for (int i = 0; i < N; i++)
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit [N-1:0] req);
        bit [N-1:0] p;
        bit up, dn;
        p = m_pend | req;
        if (m_mov) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                if (p[m_floor]) begin
                    p[m_floor] = 1'b0;
                    m_mov = 0; m_door = 1; m_left = DOOR;
                end else if (any_ahead(p, m_floor, m_dir)) begin
                    m_left = TRAVEL;
                end else begin
                    m_mov = 0;
                end
            end
        end else if (m_door) begin
            if (req[m_floor]) begin
                p[m_floor] = 1'b0;
                m_left = DOOR;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) m_door = 0;
            end
        end else begin
            if (p[m_floor]) begin
                p[m_floor] = 1'b0;
                m_door = 1; m_left = DOOR;
            end else if (p != '0) begin
                up = any_ahead(p, m_floor, 1'b1);
                dn = any_ahead(p, m_floor, 1'b0);
                m_dir = up && (m_dir || !dn);
                m_mov = 1; m_left = TRAVEL;
            end
        end
        m_pend = p;
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_floor = 0; m_pend = '0; m_mov = 0; m_door = 0; m_dir = 1; m_left = 0;
        end else begin
            model_step(floor_req);
        end
    end

    initial forever begin
        logic [N-1:0] exp_pos;
        @(negedge clk);
        if (cmp_en) begin
            exp_pos = '0;
            exp_pos[m_floor] = 1'b1;
            tests++;
            if ({floor_pos, pending, moving, door_open, dir_up} !==
                {exp_pos, m_pend, m_mov, m_door, m_dir}) begin
                fails++;
                $display("FAIL model t=%0t: got pos=%b pend=%b mov=%b door=%b up=%b expected pos=%b pend=%b mov=%b door=%b up=%b",
                         $time, floor_pos, pending, moving, door_open, dir_up,
                         exp_pos, m_pend, m_mov, m_door, m_dir);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, act[N-1:0], exp[N-1:0]);
        end
    endtask

    task automatic pulse(input logic [N-1:0] r);
        floor_req = r;
        @(negedge clk);
        floor_req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        floor_req = 5'b11111;
        repeat (2) @(negedge clk);
        floor_req = '0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        floor_req = '0;
        #2 reset = 1'b0;
        #1 cmp_en = 1'b1;
        check("rst_pos", floor_pos, 5'b00001);
        check("rst_pend", pending, 5'b00000);
        check("rst_flags", {moving, door_open, dir_up}, 3'b001);
        @(negedge clk);
        reset = 1'b1;

        // Single call to floor 3 from floor 1.
        pulse(5'b00100);
        check("a_moving", moving, 1'b1);
        check("a_pend", pending, 5'b00100);
        repeat (3) @(negedge clk);
        check("a_pos_before", floor_pos, 5'b00001);
        @(negedge clk);
        check("a_pos_f2", floor_pos, 5'b00010);
        repeat (4) @(negedge clk);
        check("a_pos_f3", floor_pos, 5'b00100);
        check("a_door", door_open, 1'b1);
        check("a_pend_clr", pending, 5'b00000);
        repeat (2) @(negedge clk);
        check("a_door_last", door_open, 1'b1);
        @(negedge clk);
        check("a_idle", {moving, door_open}, 2'b00);

        // Call for the current floor while idle.
        do_reset();
        pulse(5'b00001);
        for (int i = 1; i <= 4; i++) begin
            check("b_door", door_open, (i <= DOOR) ? 1'b1 : 1'b0);
            check("b_nomove", moving, 1'b0);
            @(negedge clk);
        end

        // Two calls on one sweep, intermediate floor skipped.
        do_reset();
        pulse(5'b01010);
        repeat (4) @(negedge clk);
        check("c_stop_f2", {floor_pos, door_open}, {5'b00010, 1'b1});
        check("c_pend", pending, 5'b01000);
        repeat (3) @(negedge clk);
        check("c_idle", {moving, door_open}, 2'b00);
        @(negedge clk);
        check("c_moving", moving, 1'b1);
        repeat (4) @(negedge clk);
        check("c_pass_f3", {floor_pos, moving, door_open}, {5'b00100, 2'b10});
        repeat (4) @(negedge clk);
        check("c_stop_f4", {floor_pos, door_open}, {5'b01000, 1'b1});
        check("c_pend_clr", pending, 5'b00000);

        // Call behind the car waits for the reverse sweep.
        do_reset();
        pulse(5'b10000);
        repeat (9) @(negedge clk);
        check("d_at_f3", {floor_pos, moving}, {5'b00100, 1'b1});
        pulse(5'b00001);
        check("d_pend", pending, 5'b10001);
        repeat (6) @(negedge clk);
        check("d_top", {floor_pos, door_open}, {5'b10000, 1'b1});
        check("d_pend_top", pending, 5'b00001);
        repeat (3) @(negedge clk);
        check("d_idle_dir", {moving, door_open, dir_up}, 3'b001);
        @(negedge clk);
        check("d_down", {moving, dir_up}, 2'b10);
        repeat (16) @(negedge clk);
        check("d_bottom", {floor_pos, door_open}, {5'b00001, 1'b1});
        check("d_pend_clr", pending, 5'b00000);

        // Door hold extended by a call for the same floor on its last cycle.
        do_reset();
        pulse(5'b00010);
        repeat (6) @(negedge clk);
        check("e_door_last", {floor_pos, door_open}, {5'b00010, 1'b1});
        pulse(5'b00010);
        check("e_door_ext1", door_open, 1'b1);
        check("e_pend", pending, 5'b00000);
        repeat (2) @(negedge clk);
        check("e_door_ext3", door_open, 1'b1);
        @(negedge clk);
        check("e_door_off", door_open, 1'b0);

        // Asynchronous reset in the middle of a move.
        do_reset();
        pulse(5'b10000);
        repeat (6) @(negedge clk);
        check("f_mid", {floor_pos, pending, moving}, {5'b00010, 5'b10000, 1'b1});
        #1 reset = 1'b0;
        #1;
        check("f_rst_pos", floor_pos, 5'b00001);
        check("f_rst_pend", pending, 5'b00000);
        check("f_rst_flags", {moving, door_open, dir_up}, 3'b001);
        floor_req = 5'b10101;
        repeat (2) @(negedge clk);
        check("f_ignored", pending, 5'b00000);
        floor_req = '0;
        reset = 1'b1;
        @(negedge clk);
        check("f_after", {floor_pos, pending, moving}, {5'b00001, 5'b00000, 1'b0});

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
